// File: rtl/cpu6502_pkg.sv
// Shared 6502-core constants: opcode reset value, retire-length encodings
// and the smallest prefetch-queue depth that still holds a 3-byte instruction.
package cpu6502_pkg;

  localparam logic [7:0] OPC_BRK = 8'h00;

  typedef enum logic [1:0] {
    LEN_NONE = 2'd0,
    LEN_1    = 2'd1,
    LEN_2    = 2'd2,
    LEN_3    = 2'd3
  } rd_len_e;

  localparam int MIN_QUEUE_DEPTH = 4;

endpackage

// File: rtl/prefetch_fifo_mem.sv
// DEPTH x DATA_W byte storage for the prefetch queue: one synchronous write
// port and three combinational read ports forming the peek window.
module prefetch_fifo_mem #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr0,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are never reset; peek_valid tells consumers which slots are live.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/instruction_prefetch_queue.sv
// Byte FIFO between the memory data bus and the control FSM: exposes a
// three-byte peek window and retires whole 1-3 byte instructions per strobe.
module instruction_prefetch_queue
  import cpu6502_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              FSM_Signal,
  input  logic              reset_IR_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [1:0]        rd_len,
  input  logic              flush,
  output logic [DATA_W-1:0] peek_op,
  output logic [DATA_W-1:0] peek_lo,
  output logic [DATA_W-1:0] peek_hi,
  output logic [2:0]        peek_valid,
  output logic [DATA_W-1:0] OUT_IR,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              wr_ack,
  output logic              rd_err
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_addr_lo;
  logic [AW-1:0]    rd_addr_hi;
  logic [CNT_W-1:0] len_cnt;
  logic [CNT_W-1:0] count_nxt;
  logic             len_legal;
  logic             push_ok;
  logic             retire_ok;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign peek_valid[0] = (count > CNT_W'(0));
  assign peek_valid[1] = (count > CNT_W'(1));
  assign peek_valid[2] = (count > CNT_W'(2));

  // Acceptance uses pre-edge occupancy, so a full queue never passes a byte through.
  assign len_cnt   = CNT_W'(rd_len);
  assign len_legal = (rd_len_e'(rd_len) != LEN_NONE) && (len_cnt <= count);
  assign push_ok   = wr_en && !full;
  assign retire_ok = rd_en && len_legal;
  assign count_nxt = count + CNT_W'(push_ok) - (retire_ok ? len_cnt : '0);

  assign rd_addr_lo = rd_ptr + AW'(1);
  assign rd_addr_hi = rd_ptr + AW'(2);

  prefetch_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk    (FSM_Signal),
    .we     (push_ok && !flush),
    .waddr  (wr_ptr),
    .wdata  (wr_data),
    .raddr0 (rd_ptr),
    .raddr1 (rd_addr_lo),
    .raddr2 (rd_addr_hi),
    .rdata0 (peek_op),
    .rdata1 (peek_lo),
    .rdata2 (peek_hi)
  );

  // Flush outranks push and retire but keeps the last retired opcode.
  always_ff @(posedge FSM_Signal or negedge reset_IR_n) begin
    if (!reset_IR_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      OUT_IR <= DATA_W'(OPC_BRK);
      wr_ack <= 1'b0;
      rd_err <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      wr_ack <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (retire_ok) begin
        rd_ptr <= rd_ptr + AW'(rd_len);
        OUT_IR <= peek_op;
      end
      count  <= count_nxt;
      wr_ack <= push_ok;
      rd_err <= rd_en && !retire_ok;
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Directed and randomized checks of instruction_prefetch_queue against a
// queue-based reference model of the prefetch buffer.
module tb_instruction_prefetch_queue;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              FSM_Signal;
  logic              reset_IR_n;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [1:0]        rd_len;
  logic              flush;
  logic [DATA_W-1:0] peek_op;
  logic [DATA_W-1:0] peek_lo;
  logic [DATA_W-1:0] peek_hi;
  logic [2:0]        peek_valid;
  logic [DATA_W-1:0] OUT_IR;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              wr_ack;
  logic              rd_err;

  instruction_prefetch_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .FSM_Signal (FSM_Signal),
    .reset_IR_n (reset_IR_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_len     (rd_len),
    .flush      (flush),
    .peek_op    (peek_op),
    .peek_lo    (peek_lo),
    .peek_hi    (peek_hi),
    .peek_valid (peek_valid),
    .OUT_IR     (OUT_IR),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .rd_err     (rd_err)
  );

  initial FSM_Signal = 1'b0;
  always #5 FSM_Signal = ~FSM_Signal;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: queued bytes in arrival order plus registered flags.
  logic [7:0] mq[$];
  logic [7:0] m_ir;
  logic       m_ack;
  logic       m_err;

  task automatic model_reset();
    mq.delete();
    m_ir  = 8'h00;
    m_ack = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    int  sz;
    bit  push_ok;
    bit  ret_ok;
    sz = mq.size();
    if (flush) begin
      mq.delete();
      m_ack = 1'b0;
      m_err = 1'b0;
    end else begin
      push_ok = wr_en && (sz < DEPTH);
      ret_ok  = rd_en && (rd_len != 0) && (int'(rd_len) <= sz);
      if (ret_ok) begin
        m_ir = mq[0];
        for (int k = 0; k < int'(rd_len); k++) void'(mq.pop_front());
      end
      if (push_ok) mq.push_back(wr_data);
      m_ack = push_ok;
      m_err = rd_en && !ret_ok;
    end
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r,
                       input logic [1:0] l, input logic f);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    rd_len  = l;
    flush   = f;
  endtask

  // One strobe: model sees the pre-edge state, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge FSM_Signal);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    drive(0, 8'h00, 0, 2'd0, 0);
    reset_IR_n = 1'b0;
    model_reset();
    #7;
    vectors++;
    if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || peek_valid !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_status: count=%0d empty=%b full=%b pv=%b expected 0/1/0/000",
               count, empty, full, peek_valid);
    end
    vectors++;
    if (OUT_IR !== 8'h00 || wr_ack !== 1'b0 || rd_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_regs: OUT_IR=%h wr_ack=%b rd_err=%b expected 00/0/0",
               OUT_IR, wr_ack, rd_err);
    end
    @(posedge FSM_Signal);
    #1;
    reset_IR_n = 1'b1;
  endtask

  task automatic test_basic();
    drive(1, 8'hA9, 0, 2'd0, 0); step();
    vectors++;
    if (wr_ack !== 1'b1 || count !== 3'd1) begin
      miscompares++;
      $display("FAIL basic_push1: wr_ack=%b count=%0d expected 1/1", wr_ack, count);
    end
    drive(1, 8'h42, 0, 2'd0, 0); step();
    vectors++;
    if (count !== 3'd2 || peek_op !== 8'hA9 || peek_lo !== 8'h42 || peek_valid !== 3'b011) begin
      miscompares++;
      $display("FAIL basic_peek: count=%0d op=%h lo=%h pv=%b expected 2/a9/42/011",
               count, peek_op, peek_lo, peek_valid);
    end
    drive(0, 8'h00, 1, 2'd2, 0); step();
    vectors++;
    if (OUT_IR !== 8'hA9 || count !== 3'd0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_retire: OUT_IR=%h count=%0d empty=%b expected a9/0/1",
               OUT_IR, count, empty);
    end
  endtask

  task automatic test_full();
    logic [7:0] bytes_in [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1, bytes_in[i], 0, 2'd0, 0); step();
    end
    vectors++;
    if (full !== 1'b1 || count !== 3'd4 || peek_valid !== 3'b111) begin
      miscompares++;
      $display("FAIL full_flag: full=%b count=%0d pv=%b expected 1/4/111", full, count, peek_valid);
    end
    drive(1, 8'hFF, 0, 2'd0, 0); step();
    vectors++;
    if (wr_ack !== 1'b0 || count !== 3'd4 || peek_op !== 8'h11 || peek_lo !== 8'h22 ||
        peek_hi !== 8'h33) begin
      miscompares++;
      $display("FAIL full_reject: wr_ack=%b count=%0d op=%h lo=%h hi=%h expected 0/4/11/22/33",
               wr_ack, count, peek_op, peek_lo, peek_hi);
    end
    drive(0, 8'h00, 1, 2'd3, 0); step();
    drive(0, 8'h00, 1, 2'd1, 0); step();
    vectors++;
    if (OUT_IR !== 8'h44 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL full_drain: OUT_IR=%h empty=%b expected 44/1 (ff must not be stored)",
               OUT_IR, empty);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 8'h4C, 0, 2'd0, 0); step();
    drive(1, 8'h00, 0, 2'd0, 0); step();
    drive(1, 8'h80, 0, 2'd0, 0); step();
    drive(1, 8'hEA, 1, 2'd3, 0); step();
    vectors++;
    if (count !== 3'd1 || peek_op !== 8'hEA || OUT_IR !== 8'h4C || wr_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_push_retire: count=%0d op=%h OUT_IR=%h wr_ack=%b expected 1/ea/4c/1",
               count, peek_op, OUT_IR, wr_ack);
    end
    drive(0, 8'h00, 1, 2'd1, 0); step();
    vectors++;
    if (OUT_IR !== 8'hEA || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_drain: OUT_IR=%h empty=%b expected ea/1", OUT_IR, empty);
    end
  endtask

  task automatic test_wrap();
    drive(1, 8'h10, 0, 2'd0, 0); step();
    for (int i = 1; i < 10; i++) begin
      drive(1, 8'(8'h10 + i), 1, 2'd1, 0); step();
      vectors++;
      if (OUT_IR !== 8'(8'h10 + i - 1) || count !== 3'd1 || peek_op !== 8'(8'h10 + i)) begin
        miscompares++;
        $display("FAIL wrap_%0d: OUT_IR=%h count=%0d op=%h expected %h/1/%h",
                 i, OUT_IR, count, peek_op, 8'(8'h10 + i - 1), 8'(8'h10 + i));
      end
    end
    drive(0, 8'h00, 1, 2'd1, 0); step();
    vectors++;
    if (OUT_IR !== 8'h19 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_last: OUT_IR=%h empty=%b expected 19/1", OUT_IR, empty);
    end
  endtask

  task automatic test_illegal();
    drive(1, 8'hAA, 0, 2'd0, 0); step();
    drive(1, 8'hBB, 0, 2'd0, 0); step();
    drive(0, 8'h00, 1, 2'd3, 0); step();
    vectors++;
    if (rd_err !== 1'b1 || count !== 3'd2 || peek_op !== 8'hAA || OUT_IR !== 8'h19) begin
      miscompares++;
      $display("FAIL illegal_len3: rd_err=%b count=%0d op=%h OUT_IR=%h expected 1/2/aa/19",
               rd_err, count, peek_op, OUT_IR);
    end
    drive(0, 8'h00, 0, 2'd0, 0); step();
    vectors++;
    if (rd_err !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_pulse: rd_err=%b expected 0", rd_err);
    end
    drive(0, 8'h00, 1, 2'd0, 0); step();
    vectors++;
    if (rd_err !== 1'b1 || count !== 3'd2 || OUT_IR !== 8'h19) begin
      miscompares++;
      $display("FAIL illegal_len0: rd_err=%b count=%0d OUT_IR=%h expected 1/2/19",
               rd_err, count, OUT_IR);
    end
    drive(0, 8'h00, 1, 2'd2, 0); step();
    vectors++;
    if (rd_err !== 1'b0 || OUT_IR !== 8'hAA || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_recover: rd_err=%b OUT_IR=%h empty=%b expected 0/aa/1",
               rd_err, OUT_IR, empty);
    end
  endtask

  task automatic test_flush_reset();
    drive(1, 8'h01, 0, 2'd0, 0); step();
    drive(1, 8'h02, 0, 2'd0, 0); step();
    drive(1, 8'h03, 0, 2'd0, 0); step();
    drive(1, 8'h55, 1, 2'd1, 1); step();
    vectors++;
    if (count !== 3'd0 || wr_ack !== 1'b0 || rd_err !== 1'b0 || OUT_IR !== 8'hAA) begin
      miscompares++;
      $display("FAIL flush: count=%0d wr_ack=%b rd_err=%b OUT_IR=%h expected 0/0/0/aa",
               count, wr_ack, rd_err, OUT_IR);
    end
    drive(1, 8'h77, 0, 2'd0, 0); step();
    vectors++;
    if (peek_op !== 8'h77 || count !== 3'd1) begin
      miscompares++;
      $display("FAIL flush_ptr: op=%h count=%0d expected 77/1", peek_op, count);
    end
    drive(1, 8'h78, 1, 2'd1, 0); step();
    drive(0, 8'h00, 0, 2'd0, 0);
    #2;
    reset_IR_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (OUT_IR !== 8'h00 || count !== 3'd0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: OUT_IR=%h count=%0d empty=%b expected 00/0/1",
               OUT_IR, count, empty);
    end
    #1;
    reset_IR_n = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] pk [3];
    logic [2:0] exp_pv;
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 19) == 0));
      step();
      exp_pv = {mq.size() > 2, mq.size() > 1, mq.size() > 0};
      pk[0] = peek_op;
      pk[1] = peek_lo;
      pk[2] = peek_hi;
      vectors++;
      if (count !== CNT_W'(mq.size()) || peek_valid !== exp_pv ||
          full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin
        miscompares++;
        $display("FAIL rand_status_%0d: count=%0d pv=%b full=%b empty=%b expected count=%0d pv=%b",
                 n, count, peek_valid, full, empty, mq.size(), exp_pv);
      end
      vectors++;
      if (OUT_IR !== m_ir || wr_ack !== m_ack || rd_err !== m_err) begin
        miscompares++;
        $display("FAIL rand_regs_%0d: OUT_IR=%h wr_ack=%b rd_err=%b expected %h/%b/%b",
                 n, OUT_IR, wr_ack, rd_err, m_ir, m_ack, m_err);
      end
      for (int k = 0; k < 3; k++) begin
        if (k < mq.size()) begin
          vectors++;
          if (pk[k] !== mq[k]) begin
            miscompares++;
            $display("FAIL rand_peek%0d_%0d: got %h expected %h", k, n, pk[k], mq[k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_wrap();
    test_illegal();
    test_flush_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_prefetch_queue.md
Name: instruction_prefetch_queue

Overview:
Parametrised successor to the single-byte instruction register. It is a DEPTH-entry byte FIFO between the memory data bus and the control FSM, clocked by the FSM strobe. It buffers prefetched opcode/operand bytes, exposes the next three bytes as a peek window, and lets the FSM retire a whole 1-3 byte instruction in one cycle. On each retire, the retired opcode is latched into an IR-style holding register.

Parameters:
DATA_W, 8, byte width of the data path
DEPTH, 4, queue entries; power of two, minimum 4
CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived, not overridable)

Ports:
FSM_Signal  in  1  clock; all state changes on its rising edge
reset_IR_n  in  1  asynchronous active-low reset
wr_en  in  1  push request for wr_data
wr_data  in  DATA_W  byte from the memory data bus
rd_en  in  1  retire-instruction request
rd_len  in  2  bytes to retire: 1..3; 0 is illegal
flush  in  1  discard all queued bytes (branch, jump, interrupt)
peek_op  out  DATA_W  entry at the read pointer (opcode candidate)
peek_lo  out  DATA_W  entry at read pointer+1
peek_hi  out  DATA_W  entry at read pointer+2
peek_valid  out  3  bit i set when count > i
OUT_IR  out  DATA_W  last retired opcode
count  out  CNT_W  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
wr_ack  out  1  registered; push accepted last cycle
rd_err  out  1  registered one-cycle pulse; illegal retire rejected

Behaviour:
- Reset (async assert, sync release): pointers, count, OUT_IR, wr_ack and rd_err go to 0. empty=1, full=0, peek_valid=0. Storage contents are don't-care.
- Push is accepted iff wr_en && !full, with full sampled before the edge. There is no same-cycle pass-through when full. An accepted push writes wr_data at the write pointer, and the pointer advances mod DEPTH.
- Retire is accepted iff rd_en && rd_len != 0 && rd_len <= count, with count sampled before the edge. An accepted retire:
  - sets OUT_IR <= peek_op;
  - advances the read pointer by rd_len mod DEPTH.
- A rejected retire changes no state and pulses rd_err for one cycle.
- Simultaneous accepted push and retire: next count = count + 1 - rd_len. The pushed byte is never visible in the same cycle's peek.
- flush has highest priority. Pointers and count go to 0 and any same-cycle push or retire is ignored. wr_ack=0 and rd_err=0 that cycle. OUT_IR is retained.
- Peek outputs are combinational from storage at the read pointer, +1 and +2 (mod DEPTH), with zero latency. Values are don't-care where the corresponding peek_valid bit is 0.
- full, empty and peek_valid are combinational decodes of count. Pointer wrap-around is natural binary modulo DEPTH.
- Latency: a byte pushed at edge N is visible on peek/count after edge N. OUT_IR updates after the retire edge.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.

Decomposition:
- Shared package cpu6502_pkg holds:
  - constant OPC_BRK = 8'h00 (OUT_IR reset value);
  - the LEN_1/LEN_2/LEN_3 rd_len encodings;
  - MIN_QUEUE_DEPTH = 4.
- One natural sub-module: prefetch_fifo_mem. It contains the DEPTH x DATA_W storage with one write port and three combinational read ports. Pointer, count and OUT_IR logic stay in the top level.

Test Plan:
- Reset then push 0xA9, 0x42 -> count=2, peek_op=0xA9, peek_lo=0x42, peek_valid=3'b011; rd_en with rd_len=2 -> OUT_IR=0xA9, count=0, empty=1.
- Push 4 bytes with DEPTH=4 -> full=1; a fifth push of 0xFF -> wr_ack=0, count stays 4, contents unchanged.
- With count=3 holding 0x4C,0x00,0x80: push 0xEA and retire rd_len=3 in the same cycle -> count=1, peek_op=0xEA, OUT_IR=0x4C.
- Wrap: repeatedly push/retire 1 byte for 10 cycles with data 0x10..0x19 -> each retire yields OUT_IR equal to the pushed byte, and the pointers wrap with no corruption.
- Illegal retires: rd_len=3 with count=2 -> rd_err pulse, no state change; rd_len=0 -> rd_err pulse.
- Flush together with push 0x55 at count=3 -> count=0, wr_ack=0, OUT_IR unchanged. Then assert reset_IR_n low between edges -> OUT_IR=0x00 and count=0 immediately.
